// File: rtl/fast_fifo_drain.sv
// Consumer-side drain for FastFIFO: credit-limited read requests, in-flight tracking
// over the fixed read latency, and a small skid queue presented as a valid/ready stream.
module fast_fifo_drain #(
  parameter int WIDTH           = 20,
  parameter int READ_LATENCY    = 0,
  parameter int SKID_DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drainEnable,
  input  logic             fifoEmpty,
  output logic             fifoReadRequest,
  input  logic [WIDTH-1:0] fifoDataOut,
  input  logic             fifoDataOutValid,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic             quiescent,
  output logic             protocolError
);

  localparam int SKID_ENTRIES = 1 << SKID_DEPTH_LOG2;
  localparam logic [SKID_DEPTH_LOG2:0] SKID_FULL = (SKID_DEPTH_LOG2+1)'(SKID_ENTRIES);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] STOPPING = 2'd1;
  localparam logic [1:0] STOPPED  = 2'd2;

  generate
    if (SKID_ENTRIES < READ_LATENCY + 1 || READ_LATENCY > 8) begin : g_bad_cfg
      $error("fast_fifo_drain: skid queue too small for READ_LATENCY, or READ_LATENCY > 8");
    end
  endgenerate

  logic [WIDTH-1:0]           skid [SKID_ENTRIES];
  logic [SKID_DEPTH_LOG2-1:0] wr_ptr;
  logic [SKID_DEPTH_LOG2-1:0] rd_ptr;
  logic [SKID_DEPTH_LOG2:0]   skid_count;
  logic [1:0]                 state;
  logic [3:0]                 ignore_cnt;
  logic [3:0]                 pending;
  logic                       due;
  logic [7:0]                 credit_sum;
  logic                       credit_ok;
  logic                       pop;
  logic                       arrive;
  logic                       overflow;
  logic                       error_now;
  logic                       push;

  // One bit per issued request; the oldest bit marks the word that should return now.
  generate
    if (READ_LATENCY > 0) begin : g_pipe
      logic [READ_LATENCY-1:0] req_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_pipe <= '0;
        else        req_pipe <= (req_pipe << 1) | READ_LATENCY'(fifoReadRequest);
      end

      always_comb begin
        pending = '0;
        for (int i = 0; i < READ_LATENCY; i++) pending = pending + 4'(req_pipe[i]);
      end

      assign due = req_pipe[READ_LATENCY-1];
    end else begin : g_nopipe
      assign pending = '0;
      assign due     = fifoReadRequest;
    end
  endgenerate

  assign credit_sum      = 8'(skid_count) + 8'(pending);
  assign credit_ok       = credit_sum < 8'(SKID_ENTRIES);
  assign fifoReadRequest = rst_n && (state == RUN) && !fifoEmpty && credit_ok;

  assign outValid  = (skid_count != '0);
  assign outData   = skid[rd_ptr];
  assign pop       = outValid && outReady;
  assign quiescent = (pending == '0) && (skid_count == '0) && !fifoReadRequest;

  // Words still returning from before a reset are swallowed silently during ignore_cnt.
  assign arrive    = fifoDataOutValid && (ignore_cnt == '0);
  assign overflow  = (skid_count == SKID_FULL) && !pop;
  assign error_now = arrive && (!due || overflow);
  assign push      = arrive && !error_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_ENTRIES; i++) skid[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      skid_count    <= '0;
      state         <= RUN;
      ignore_cnt    <= 4'(READ_LATENCY);
      protocolError <= 1'b0;
    end else begin
      if (ignore_cnt != '0) ignore_cnt <= ignore_cnt - 1'b1;

      if (push) begin
        skid[wr_ptr] <= fifoDataOut;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      skid_count <= skid_count + 1'b1;
      else if (pop && !push) skid_count <= skid_count - 1'b1;

      if (error_now) protocolError <= 1'b1;

      case (state)
        RUN:      if (!drainEnable) state <= STOPPING;
        STOPPING: if (drainEnable) state <= RUN;
                  else if (pending == '0) state <= STOPPED;
        STOPPED:  if (drainEnable) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_fifo_drain.sv
// Directed bench for fast_fifo_drain (LAT=2, 4-entry skid) against a behavioural
// FastFIFO with optional request rate limiting; output stream checked by a scoreboard.
module tb_fast_fifo_drain;

  localparam int WIDTH = 20;
  localparam int LAT   = 2;
  localparam int LOG2  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             drainEnable = 1'b1;
  logic             fifoEmpty;
  logic             fifoReadRequest;
  logic [WIDTH-1:0] fifoDataOut;
  logic             fifoDataOutValid;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady = 1'b0;
  logic             quiescent;
  logic             protocolError;

  int tests = 0;
  int fails = 0;

  fast_fifo_drain #(.WIDTH(WIDTH), .READ_LATENCY(LAT), .SKID_DEPTH_LOG2(LOG2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .drainEnable      (drainEnable),
    .fifoEmpty        (fifoEmpty),
    .fifoReadRequest  (fifoReadRequest),
    .fifoDataOut      (fifoDataOut),
    .fifoDataOutValid (fifoDataOutValid),
    .outData          (outData),
    .outValid         (outValid),
    .outReady         (outReady),
    .quiescent        (quiescent),
    .protocolError    (protocolError)
  );

  always #5 clk = ~clk;

  // Behavioural FastFIFO: honours one in rate_div requests, returns data LAT cycles later.
  logic [WIDTH-1:0] mem [0:127];
  int               rd_idx = 0;
  int               wr_cnt = 0;
  int               rate_div = 1;
  int               rl_cnt = 0;
  int               req_issued = 0;
  logic [1:0]       pv = 2'b00;
  logic [WIDTH-1:0] pd0 = '0;
  logic [WIDTH-1:0] pd1 = '0;
  logic             inj = 1'b0;

  assign fifoEmpty        = (rd_idx == wr_cnt);
  assign fifoDataOutValid = pv[1] | inj;
  assign fifoDataOut      = pd1;

  always @(posedge clk) begin
    pv[1] <= pv[0];
    pd1   <= pd0;
    pv[0] <= 1'b0;
    if (fifoReadRequest) req_issued <= req_issued + 1;
    if (fifoReadRequest && !fifoEmpty) begin
      rl_cnt <= (rl_cnt + 1 >= rate_div) ? 0 : rl_cnt + 1;
      if (rl_cnt == 0) begin
        pv[0]  <= 1'b1;
        pd0    <= mem[rd_idx];
        rd_idx <= rd_idx + 1;
      end
    end
  end

  logic [WIDTH-1:0] exp_q [$];
  int               cyc = 0;
  int               pops = 0;
  int               first_pop = 0;
  int               last_pop = 0;

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic load_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_cnt] = WIDTH'(first + i);
      exp_q.push_back(WIDTH'(first + i));
      wr_cnt++;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || outValid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted output word must be the next expected one.
  initial begin
    logic [WIDTH-1:0] expv;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && outValid && outReady) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("[TB] FAIL sb_unexpected: observed %0h expected none", outData);
        end else begin
          expv = exp_q.pop_front();
          check_output("sb_data", outData, expv);
        end
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end
  end

  initial begin
    int r0;
    int n;

    outReady = 1'b1;
    load_words(1, 10);
    step(2);
    check_output("rst_outValid", outValid, 0);
    check_output("rst_outData", outData, 0);
    check_output("rst_quiescent", quiescent, 1);
    check_output("rst_readReq", fifoReadRequest, 0);
    check_output("rst_perr", protocolError, 0);

    // Streaming with no backpressure
    pops = 0;
    rst_n = 1'b1;
    wait_drain("t1", 80);
    check_output("t1_pops", pops, 10);
    check_output("t1_b2b_span", last_pop - first_pop, 9);
    check_output("t1_perr", protocolError, 0);

    // Full backpressure: credits cap requests at the skid depth
    outReady = 1'b0;
    r0 = req_issued;
    load_words(11, 10);
    step(20);
    check_output("t2_req_count", req_issued - r0, 4);
    check_output("t2_outValid", outValid, 1);
    check_output("t2_outData", outData, 11);
    step(3);
    check_output("t2_hold", outData, 11);
    outReady = 1'b1;
    wait_drain("t2", 80);

    // Rate-limited FIFO ignores two of every three requests
    rate_div = 3;
    r0 = req_issued;
    load_words(21, 10);
    wait_drain("t3", 400);
    check_output("t3_req_retries", req_issued - r0, 28);
    check_output("t3_perr", protocolError, 0);
    rate_div = 1;

    // Stop mid-stream, confirm quiescence, then resume
    load_words(31, 20);
    step(8);
    drainEnable = 1'b0;
    n = 0;
    while (!quiescent && n < 50) begin
      step(1);
      n++;
    end
    r0 = req_issued;
    step(10);
    check_output("t4_quiescent", quiescent, 1);
    check_output("t4_no_req", req_issued - r0, 0);
    check_output("t4_outValid", outValid, 0);
    check_output("t4_inflight_delivered", exp_q.size(), wr_cnt - rd_idx);
    drainEnable = 1'b1;
    wait_drain("t4", 120);

    // Unrequested data word
    drainEnable = 1'b0;
    step(5);
    check_output("t5_perr_before", protocolError, 0);
    inj = 1'b1;
    step(1);
    inj = 1'b0;
    check_output("t5_perr_set", protocolError, 1);
    check_output("t5_dropped", outValid, 0);
    step(5);
    check_output("t5_perr_sticky", protocolError, 1);
    rst_n = 1'b0;
    #1;
    check_output("t5_perr_cleared", protocolError, 0);
    step(1);
    rst_n = 1'b1;
    drainEnable = 1'b1;
    step(4);

    // Reset while words are queued and in flight
    load_words(51, 20);
    step(6);
    rst_n = 1'b0;
    #1;
    check_output("t6_outValid_reset", outValid, 0);
    step(1);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = rd_idx; i < wr_cnt; i++) exp_q.push_back(mem[i]);
    wait_drain("t6", 120);
    check_output("t6_perr", protocolError, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
